// File: rtl/floating_alu_pipe.sv
// rtl/floating_alu_pipe.sv - pipelined fma unit with tag pipe, writeback FIFO, credit busy and flush.
// Optional signalling-NaN exception reporting under FLOATING_ALU_PIPE_EXC_EN.
module floating_alu_pipe #(
   parameter int FW         = 23,
   parameter int EW         = 8,
   parameter int LATENCY    = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int DEST_W     = 6,
   parameter int TICKET_W   = 4,
   localparam int DW        = FW + EW + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid_i,
   input  logic [2:0]          rm_i,
   input  logic [3:0]          op_i,
   input  logic [DW-1:0]       opa_i,
   input  logic [DW-1:0]       opb_i,
   input  logic [DW-1:0]       opc_i,
   input  logic [DEST_W-1:0]   dest_i,
   input  logic [TICKET_W-1:0] ticket_i,
   input  logic                flush_i,
   output logic                busy_o,
   output logic                wb_valid_o,
   input  logic                wb_ready_i,
   output logic [DW-1:0]       wb_data_o,
   output logic [DEST_W-1:0]   wb_dest_o,
   output logic [TICKET_W-1:0] wb_ticket_o,
   output logic                wb_exc_o,
   output logic [4:0]          wb_cause_o
);
   localparam int MW   = FW + 1;
   localparam int G    = FW + 3;
   localparam int W    = 2 * MW + G;
   localparam int BIAS = (1 << (EW - 1)) - 1;
   localparam int EMAX = (1 << EW) - 1;
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CW   = $clog2(FIFO_DEPTH + 1);
   localparam logic [DW-1:0] ONE  = {2'b00, {(EW-1){1'b1}}, {FW{1'b0}}};
   localparam logic [DW-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};

   // op_i: 0 fmadd, 1 fmsub, 2 fnmsub, 3 fnmadd, 4 fmul (C unused), 5 fadd (B unused)
   logic            is_mul, is_add, neg_p, neg_c, special;
   logic [DW-1:0]   b_eff, c_eff, core_res;
   logic [MW-1:0]   ma, mb, mc;
   logic [2*MW-1:0] prod;
   logic [W-1:0]    pf, cf, pal, cal;
   logic [W:0]      m, norm;
   logic            sp, sc, rs, grd, stk, inc;
   logic [FW-1:0]   frac;
   logic [EW+FW-1:0] mag;
   int              ep, ec, emax, er, p;

   always_comb begin
      is_mul  = (op_i == 4'd4);
      is_add  = (op_i == 4'd5);
      neg_p   = (op_i == 4'd2) || (op_i == 4'd3);
      neg_c   = (op_i == 4'd1) || (op_i == 4'd3);
      b_eff   = is_add ? ONE : opb_i;
      c_eff   = is_mul ? '0 : opc_i;
      // infinities and NaNs collapse to the canonical quiet NaN; subnormals read as zero
      special = (&opa_i[DW-2:FW]) || (&b_eff[DW-2:FW]) || (&c_eff[DW-2:FW]);
      ma      = (opa_i[DW-2:FW] == '0) ? '0 : {1'b1, opa_i[FW-1:0]};
      mb      = (b_eff[DW-2:FW] == '0) ? '0 : {1'b1, b_eff[FW-1:0]};
      mc      = (c_eff[DW-2:FW] == '0) ? '0 : {1'b1, c_eff[FW-1:0]};
      prod    = {{MW{1'b0}}, ma} * {{MW{1'b0}}, mb};
      ep      = int'(opa_i[DW-2:FW]) + int'(b_eff[DW-2:FW]) - BIAS;
      ec      = int'(c_eff[DW-2:FW]);
      if (prod == '0) ep = ec;
      if (mc == '0) ec = ep;
      pf      = {prod, {G{1'b0}}};
      cf      = {1'b0, mc, {(FW+G){1'b0}}};
      if (ep >= ec) begin
         emax = ep;
         pal  = pf;
         cal  = cf >> (ep - ec);
      end else begin
         emax = ec;
         pal  = pf >> (ec - ep);
         cal  = cf;
      end
      sp = opa_i[DW-1] ^ b_eff[DW-1] ^ neg_p;
      sc = c_eff[DW-1] ^ neg_c;
      if (sp == sc) begin
         m  = {1'b0, pal} + {1'b0, cal};
         rs = sp;
      end else if (pal >= cal) begin
         m  = {1'b0, pal - cal};
         rs = sp;
      end else begin
         m  = {1'b0, cal - pal};
         rs = sc;
      end
      p = 0;
      for (int i = 0; i <= W; i++) begin
         if (m[i]) p = i;
      end
      er   = emax + p - (2 * FW + G);
      // shift the leading one out so the fraction sits at the top
      norm = m << (W + 1 - p);
      frac = norm[W -: FW];
      grd  = norm[W-FW];
      stk  = |norm[W-FW-1:0];
      case (rm_i)
         3'd1:    inc = 1'b0;
         3'd2:    inc = rs & (grd | stk);
         3'd3:    inc = ~rs & (grd | stk);
         3'd4:    inc = grd;
         default: inc = grd & (stk | frac[0]);
      endcase
      mag = {er[EW-1:0], frac} + {{(EW+FW-1){1'b0}}, inc};
      if (special)          core_res = QNAN;
      else if (m == '0)     core_res = '0;
      else if (er >= EMAX)  core_res = {rs, {EW{1'b1}}, {FW{1'b0}}};
      else if (er <= 0)     core_res = {rs, {(DW-1){1'b0}}};
      else                  core_res = {rs, mag};
   end

   logic [DW-1:0]       core_q     [LATENCY];
   logic [LATENCY-1:0]  tag_v;
   logic [DEST_W-1:0]   tag_dest   [LATENCY];
   logic [TICKET_W-1:0] tag_ticket [LATENCY];
   logic [DW-1:0]       mem_data   [FIFO_DEPTH];
   logic [DEST_W-1:0]   mem_dest   [FIFO_DEPTH];
   logic [TICKET_W-1:0] mem_ticket [FIFO_DEPTH];
   logic [AW:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]       cnt;
   logic                acc, pop, fifo_wr, empty, full;

   assign busy_o     = (cnt == CW'(FIFO_DEPTH));
   assign acc        = valid_i & ~busy_o & ~flush_i;
   assign empty      = (wr_ptr == rd_ptr);
   assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign wb_valid_o = ~empty & ~flush_i;
   assign pop        = wb_valid_o & wb_ready_i;
   assign fifo_wr    = tag_v[LATENCY-1];

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         tag_v  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         tag_v[0] <= acc;
         for (int i = 1; i < LATENCY; i++) tag_v[i] <= tag_v[i-1];
         if (fifo_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
         if (acc && !pop) cnt <= cnt + CW'(1);
         else if (pop && !acc) cnt <= cnt - CW'(1);
      end
   end

   // datapath is never flushed; stale entries are dropped by their cleared valid bit
   always_ff @(posedge clk) begin
      core_q[0]     <= core_res;
      tag_dest[0]   <= dest_i;
      tag_ticket[0] <= ticket_i;
      for (int i = 1; i < LATENCY; i++) begin
         core_q[i]     <= core_q[i-1];
         tag_dest[i]   <= tag_dest[i-1];
         tag_ticket[i] <= tag_ticket[i-1];
      end
      if (fifo_wr) begin
         mem_data[wr_ptr[AW-1:0]]   <= core_q[LATENCY-1];
         mem_dest[wr_ptr[AW-1:0]]   <= tag_dest[LATENCY-1];
         mem_ticket[wr_ptr[AW-1:0]] <= tag_ticket[LATENCY-1];
      end
   end

   assign wb_data_o   = wb_valid_o ? mem_data[rd_ptr[AW-1:0]]   : '0;
   assign wb_dest_o   = wb_valid_o ? mem_dest[rd_ptr[AW-1:0]]   : '0;
   assign wb_ticket_o = wb_valid_o ? mem_ticket[rd_ptr[AW-1:0]] : '0;

`ifdef FLOATING_ALU_PIPE_EXC_EN
   logic                  exc_in;
   logic [LATENCY-1:0]    tag_exc;
   logic [FIFO_DEPTH-1:0] mem_exc;

   function automatic logic is_snan(input logic [DW-1:0] x);
      return (&x[DW-2:FW]) && (x[FW-1:0] != '0) && !x[FW-1];
   endfunction

   assign exc_in = is_snan(opa_i) | (~is_add & is_snan(opb_i)) | (~is_mul & is_snan(opc_i));

   always_ff @(posedge clk) begin
      tag_exc[0] <= exc_in;
      for (int i = 1; i < LATENCY; i++) tag_exc[i] <= tag_exc[i-1];
      if (fifo_wr) mem_exc[wr_ptr[AW-1:0]] <= tag_exc[LATENCY-1];
   end

   assign wb_exc_o   = wb_valid_o & mem_exc[rd_ptr[AW-1:0]];
   assign wb_cause_o = wb_exc_o ? 5'b10000 : 5'b00000;
`else
   assign wb_exc_o   = 1'b0;
   assign wb_cause_o = 5'b00000;
`endif

   assert property (@(posedge clk) disable iff (rst) !(valid_i && busy_o));
   assert property (@(posedge clk) disable iff (rst) !(fifo_wr && full && !flush_i));

endmodule

// File: tb/tb_floating_alu_pipe.sv
// tb/tb_floating_alu_pipe.sv - directed self-checking bench for floating_alu_pipe.
// Exception expectations follow FLOATING_ALU_PIPE_EXC_EN.
module tb_floating_alu_pipe;
   logic        clk = 1'b0;
   logic        rst, valid_i, flush_i, wb_ready_i;
   logic [2:0]  rm_i;
   logic [3:0]  op_i;
   logic [31:0] opa_i, opb_i, opc_i;
   logic [5:0]  dest_i;
   logic [3:0]  ticket_i;
   logic        busy_o, wb_valid_o, wb_exc_o;
   logic [31:0] wb_data_o;
   logic [5:0]  wb_dest_o;
   logic [3:0]  wb_ticket_o;
   logic [4:0]  wb_cause_o;

   int checks = 0;
   int errors = 0;
   logic [41:0] mon_q [$];

`ifdef FLOATING_ALU_PIPE_EXC_EN
   localparam logic EXC_ON = 1'b1;
`else
   localparam logic EXC_ON = 1'b0;
`endif

   logic [3:0]  t_op  [8] = '{4'd0, 4'd4, 4'd5, 4'd1, 4'd3, 4'd2, 4'd5, 4'd0};
   logic [31:0] t_a   [8] = '{32'h3F800000, 32'h3FC00000, 32'h3F800000, 32'h40000000,
                              32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
   logic [31:0] t_b   [8] = '{32'h40000000, 32'h40800000, 32'h40400000, 32'h40000000,
                              32'h40400000, 32'h3F800000, 32'h00000000, 32'h3F800000};
   logic [31:0] t_c   [8] = '{32'h3F800000, 32'h3F800000, 32'h3F000000, 32'h3F800000,
                              32'h3F800000, 32'h3E800000, 32'hBF800000, 32'h33800000};
   logic [31:0] t_exp [8] = '{32'h40400000, 32'h40C00000, 32'h3FC00000, 32'h40400000,
                              32'hC0E00000, 32'hBF400000, 32'h00000000, 32'h3F800000};

   floating_alu_pipe #(
      .FW(23), .EW(8), .LATENCY(3), .FIFO_DEPTH(4), .DEST_W(6), .TICKET_W(4)
   ) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .rm_i(rm_i), .op_i(op_i),
      .opa_i(opa_i), .opb_i(opb_i), .opc_i(opc_i), .dest_i(dest_i), .ticket_i(ticket_i),
      .flush_i(flush_i), .busy_o(busy_o), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
      .wb_data_o(wb_data_o), .wb_dest_o(wb_dest_o), .wb_ticket_o(wb_ticket_o),
      .wb_exc_o(wb_exc_o), .wb_cause_o(wb_cause_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst && wb_valid_o && wb_ready_i)
         mon_q.push_back({wb_data_o, wb_dest_o, wb_ticket_o});
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [2:0] rm, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c, input logic [5:0] dest,
                        input logic [3:0] tkt);
      valid_i = 1'b1; op_i = op; rm_i = rm;
      opa_i = a; opb_i = b; opc_i = c; dest_i = dest; ticket_i = tkt;
   endtask

   task automatic run_single(input string tag, input logic [3:0] op, input logic [2:0] rm,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                             input logic [5:0] dest, input logic [3:0] tkt,
                             input logic [31:0] exp_d, input logic exp_x);
      wb_ready_i = 1'b1;
      step();
      drive(op, rm, a, b, c, dest, tkt);
      @(negedge clk);
      check({tag, "_v0"}, wb_valid_o, 0);
      step();
      valid_i = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check($sformatf("%s_v%0d", tag, k), wb_valid_o, (k == 4));
         if (k == 4) begin
            check({tag, "_data"}, wb_data_o, exp_d);
            check({tag, "_dest"}, wb_dest_o, dest);
            check({tag, "_ticket"}, wb_ticket_o, tkt);
            check({tag, "_exc"}, wb_exc_o, exp_x);
            check({tag, "_cause"}, wb_cause_o, exp_x ? 5'b10000 : 5'b00000);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      int n, guard;
      rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b0;
      rm_i = '0; op_i = '0; opa_i = '0; opb_i = '0; opc_i = '0; dest_i = '0; ticket_i = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy_o, 0);
      check("rst_valid", wb_valid_o, 0);
      check("rst_data", wb_data_o, 0);
      check("rst_dest", wb_dest_o, 0);
      check("rst_ticket", wb_ticket_o, 0);
      check("rst_exc", wb_exc_o, 0);
      check("rst_cause", wb_cause_o, 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_busy", busy_o, 0);

      run_single("fmadd", 4'd0, 3'd0, 32'h3F800000, 32'h40000000, 32'h3F800000,
                 6'd5, 4'd3, 32'h40400000, 1'b0);
      run_single("rup", 4'd0, 3'd3, 32'h3F800000, 32'h3F800000, 32'h33800000,
                 6'd7, 4'd1, 32'h3F800001, 1'b0);

      // back-to-back stream honouring busy_o
      mon_q.delete();
      wb_ready_i = 1'b1;
      n = 0; guard = 0;
      while (n < 8 && guard < 100) begin
         step();
         if (!busy_o) begin
            drive(t_op[n], 3'd0, t_a[n], t_b[n], t_c[n], 6'(n + 8), 4'(n));
            n++;
         end else begin
            valid_i = 1'b0;
         end
         guard++;
      end
      step();
      valid_i = 1'b0;
      guard = 0;
      while (mon_q.size() < 8 && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      check("b2b_count", mon_q.size(), 8);
      for (int i = 0; i < 8 && i < mon_q.size(); i++)
         check($sformatf("b2b_%0d", i), mon_q[i], {t_exp[i], 6'(i + 8), 4'(i)});

      // backpressure: four credits then hold-off
      mon_q.delete();
      wb_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (i == 3) check("bp_busy_pre", busy_o, 0);
         drive(t_op[i], 3'd0, t_a[i], t_b[i], t_c[i], 6'(i + 16), 4'(i));
      end
      step();
      valid_i = 1'b0;
      @(negedge clk);
      check("bp_busy", busy_o, 1);
      repeat (6) step();
      @(negedge clk);
      check("bp_hold_v", wb_valid_o, 1);
      check("bp_hold_d", wb_data_o, t_exp[0]);
      check("bp_hold_t", wb_ticket_o, 0);
      check("bp_hold_busy", busy_o, 1);
      step();
      wb_ready_i = 1'b1;
      step();
      wb_ready_i = 1'b0;
      @(negedge clk);
      check("bp_busy_rel", busy_o, 0);
      check("bp_head", wb_ticket_o, 1);
      step();
      wb_ready_i = 1'b1;
      guard = 0;
      while (mon_q.size() < 4 && guard < 30) begin
         @(negedge clk);
         guard++;
      end
      check("bp_count", mon_q.size(), 4);
      for (int i = 0; i < 4 && i < mon_q.size(); i++)
         check($sformatf("bp_%0d", i), mon_q[i], {t_exp[i], 6'(i + 16), 4'(i)});

      // flush with three ops in flight, one of them already at the FIFO head
      mon_q.delete();
      wb_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         drive(t_op[i], 3'd0, t_a[i], t_b[i], t_c[i], 6'(i + 24), 4'(i + 4));
      end
      step();
      valid_i = 1'b0;
      step();
      flush_i = 1'b1;
      wb_ready_i = 1'b1;
      @(negedge clk);
      check("flush_gate", wb_valid_o, 0);
      step();
      flush_i = 1'b0;
      check("flush_busy", busy_o, 0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check($sformatf("flush_quiet_%0d", k), wb_valid_o, 0);
         check($sformatf("flush_busy_%0d", k), busy_o, 0);
         step();
      end
      check("flush_popped", mon_q.size(), 0);
      run_single("post_flush", 4'd0, 3'd0, 32'h40000000, 32'h40400000, 32'h3F800000,
                 6'd33, 4'd9, 32'h40E00000, 1'b0);

      run_single("snan", 4'd0, 3'd0, 32'h7FA00000, 32'h3F800000, 32'h3F800000,
                 6'd12, 4'd4, 32'h7FC00000, EXC_ON);
      run_single("snan_unused", 4'd5, 3'd0, 32'h3F800000, 32'h7FA00000, 32'h3F800000,
                 6'd13, 4'd5, 32'h40000000, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
